sram_like_arbiter: RTL

Two-to-one arbiter sharing a single sram-like slave port between the instruction-side and data-side sram-like masters. It sits between the sram-to-sram-like adapters and the sram-like-to-AXI bridge. It sequences one transaction at a time: address handshake, then data return. Data side has priority, with a bounded-burst fairness rule so instruction fetch cannot starve.

---
 rtl/sram_like_arbiter_pkg.sv | 7 +
 rtl/sram_like_arbiter.sv | 88 ++++++++
 2 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg: arbiter state encoding and sram-like transfer size codes
package sram_like_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, I_ADDR, D_ADDR, I_DATA, D_DATA} state_t;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
endpackage

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: 2:1 sram-like arbiter, data priority with bounded data bursts so
// instruction fetch cannot starve; one transaction in flight, handshakes pass through
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    output logic        busy
);
    localparam int CW = $clog2(MAX_D_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_D_BURST);

    state_t        state, state_nxt;
    logic [CW-1:0] d_cnt;
    logic          gnt_i, gnt_d, in_data, addr_hs, done;

    // grant is only re-evaluated in IDLE; once a phase starts it stays with its owner
    always_comb begin
        gnt_d = state == D_ADDR || state == D_DATA ||
                (state == IDLE && data_req && (!inst_req || d_cnt < CMAX));
        gnt_i = state == I_ADDR || state == I_DATA || (state == IDLE && !gnt_d && inst_req);
    end

    assign in_data      = state == I_DATA || state == D_DATA;
    assign req          = !in_data && (gnt_i ? inst_req : gnt_d && data_req);
    assign wr           = gnt_d ? data_wr : gnt_i && inst_wr;
    assign size         = gnt_d ? data_size : gnt_i ? inst_size : '0;
    assign addr         = gnt_d ? data_addr : gnt_i ? inst_addr : '0;
    assign wdata        = gnt_d ? data_wdata : gnt_i ? inst_wdata : '0;
    assign addr_hs      = req && addr_ok;
    // data_ok only completes a transaction in X_DATA or together with its address handshake
    assign done         = in_data ? data_ok : addr_hs && data_ok;
    assign inst_addr_ok = gnt_i && addr_hs;
    assign data_addr_ok = gnt_d && addr_hs;
    assign inst_data_ok = gnt_i && done;
    assign data_data_ok = gnt_d && done;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign busy         = state != IDLE;

    always_comb begin
        state_nxt = state;
        if (in_data) begin
            if (data_ok) state_nxt = IDLE;
        end else if (addr_hs) begin
            state_nxt = data_ok ? IDLE : (gnt_d ? D_DATA : I_DATA);
        end else if (req) begin
            state_nxt = gnt_d ? D_ADDR : I_ADDR;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            d_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (inst_addr_ok || (data_addr_ok && !inst_req)) d_cnt <= '0;
            else if (data_addr_ok && d_cnt != CMAX) d_cnt <= d_cnt + CW'(1);
        end
    end
endmodule
